seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller. It succeeds the single-digit combinational decoder and drives DIGITS common-anode digits from one shared segment bus. It time-multiplexes the digits with a prescaled scan counter, latches display data on a load strobe, and adds per-digit enable, decimal points, leading-zero blanking and PWM brightness. It sits between switch/datapath logic and the board's hex/AN pins.

---
 rtl/seg7_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadowed display data, per-digit enable,
// decimal points, leading-zero blanking and PWM brightness. All outputs are registered.
module seg7_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 100000,
  parameter int DIM_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic                  lz_blank,
  input  logic [DIM_BITS-1:0]   bright,
  output logic [6:0]            hex,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     AN
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [DIM_BITS-1:0] phase_q, phase_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]          hex_q, hex_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                sub_tick;
  logic                slot_end;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   zero_from;
  logic                zero_acc;
  logic                blank_cur;
  logic                active;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_comb begin
    sub_tick = (presc_q == PRESC_LAST);
    presc_d  = sub_tick ? '0 : presc_q + PW'(1);
    phase_d  = sub_tick ? phase_q + DIM_BITS'(1) : phase_q;
    slot_end = sub_tick && (phase_q == '1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    shadow_val_d = load ? value : shadow_val_q;
    shadow_dp_d  = load ? dp : shadow_dp_q;
  end

  // zero_from[i] is set when shadow nibbles i..DIGITS-1 are all zero
  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (shadow_val_q[4*i +: 4] == 4'h0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    cur_nib   = shadow_val_q[4*idx_q +: 4];
    blank_cur = lz_blank && (idx_q != '0) && zero_from[idx_q];
    active    = (phase_q <= bright) && en_mask[idx_q] && !blank_cur;

    an_d   = '1;
    hex_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (active) begin
      an_d[idx_q] = 1'b0;
      hex_d       = seg_decode(cur_nib);
      dp_n_d      = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      hex_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      hex_q        <= hex_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
    end
  end

  assign hex  = hex_q;
  assign dp_n = dp_n_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (DIGITS=4, CLK_DIV=4, DIM_BITS=2): directed scenarios with
// literal expectations, then randomized traffic against a time-based reference model.
module tb_seg7_scan_ctrl;
  localparam int DIGITS = 4, CLK_DIV = 4, DIM_BITS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  en_mask = '0;
  logic [1:0]  bright = '0;
  logic [6:0]  hex;
  logic        dp_n;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DIM_BITS(DIM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .en_mask(en_mask),
    .lz_blank(lz_blank), .bright(bright), .hex(hex), .dp_n(dp_n), .AN(an)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference: n edges since reset release; prescaler = n%4, phase = (n/4)%4, index = (n/16)%4
  int          n_m = 0;
  int          ph, ix;
  logic        blk;
  logic [15:0] sh_v = '0;
  logic [3:0]  sh_dp = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_hex = 7'h7F;
  logic        exp_dpn = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_m = 0; sh_v = '0; sh_dp = '0;
      exp_an = 4'hF; exp_hex = 7'h7F; exp_dpn = 1'b1;
    end else begin
      ph  = (n_m / 4) % 4;
      ix  = (n_m / 16) % 4;
      blk = lz_blank && (ix > 0) && ((sh_v >> (4 * ix)) == 16'h0);
      if (ph <= int'(bright) && en_mask[ix] && !blk) begin
        exp_an     = 4'hF;
        exp_an[ix] = 1'b0;
        exp_hex    = seg_tab[sh_v[4*ix +: 4]];
        exp_dpn    = ~sh_dp[ix];
      end else begin
        exp_an = 4'hF; exp_hex = 7'h7F; exp_dpn = 1'b1;
      end
      if (load) begin
        sh_v  = value;
        sh_dp = dp;
      end
      n_m++;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_an",  {12'h0, an},   {12'h0, exp_an});
    chk("model_hex", {9'h0, hex},   {9'h0, exp_hex});
    chk("model_dpn", {15'h0, dp_n}, {15'h0, exp_dpn});
  end

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] h, input logic d);
    chk({name, "_an"},  {12'h0, an},   {12'h0, a});
    chk({name, "_hex"}, {9'h0, hex},   {9'h0, h});
    chk({name, "_dpn"}, {15'h0, dp_n}, {15'h0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int t);
    while (ecnt < t) step();
  endtask

  logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  initial begin
    #1 rst_n = 1'b0;
    #20;
    lit("reset", 4'hF, 7'h7F, 1'b1);

    // Scenario 1: full brightness scan of 12AF
    value = 16'h12AF; dp = 4'h0; en_mask = 4'hF; bright = 2'd3; lz_blank = 1'b0; load = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
    step(); load = 1'b0;
    lit("s1_first_old_shadow", 4'b1110, 7'b1000000, 1'b1);
    run_to(2);  lit("s1_d0_start", 4'b1110, 7'b0001110, 1'b1);
    run_to(16); lit("s1_d0_end",   4'b1110, 7'b0001110, 1'b1);
    run_to(17); lit("s1_d1_start", 4'b1101, 7'b0001000, 1'b1);
    run_to(32); lit("s1_d1_end",   4'b1101, 7'b0001000, 1'b1);
    run_to(33); lit("s1_d2",       4'b1011, 7'b0100100, 1'b1);
    run_to(49); lit("s1_d3_start", 4'b0111, 7'b1111001, 1'b1);
    run_to(64); lit("s1_d3_end",   4'b0111, 7'b1111001, 1'b1);
    run_to(65); lit("s1_wrap",     4'b1110, 7'b0001110, 1'b1);

    // Scenario 2: minimum brightness
    run_to(80); bright = 2'd0;
    run_to(81); lit("s2_on_first",  4'b1101, 7'b0001000, 1'b1);
    run_to(84); lit("s2_on_last",   4'b1101, 7'b0001000, 1'b1);
    run_to(85); lit("s2_off_first", 4'b1111, 7'h7F, 1'b1);
    run_to(96); lit("s2_off_last",  4'b1111, 7'h7F, 1'b1);

    // Scenario 3: leading-zero blanking
    value = 16'h0050; lz_blank = 1'b1; bright = 2'd3; load = 1'b1;
    step(); load = 1'b0;
    run_to(100); lit("s3_d2_blank", 4'b1111, 7'h7F, 1'b1);
    run_to(120); lit("s3_d3_blank", 4'b1111, 7'h7F, 1'b1);
    run_to(130); lit("s3_d0_zero",  4'b1110, 7'b1000000, 1'b1);
    run_to(150); lit("s3_d1_five",  4'b1101, 7'b0010010, 1'b1);
    run_to(160); value = 16'h0000; load = 1'b1;
    step(); load = 1'b0;
    run_to(170); lit("s3z_d2_blank", 4'b1111, 7'h7F, 1'b1);
    run_to(200); lit("s3z_d0_zero",  4'b1110, 7'b1000000, 1'b1);
    run_to(215); lit("s3z_d1_blank", 4'b1111, 7'h7F, 1'b1);

    // Scenario 4: enable mask and decimal point
    run_to(224);
    en_mask = 4'b1010; dp = 4'b0010; value = 16'h8888; lz_blank = 1'b0; load = 1'b1;
    step(); load = 1'b0;
    run_to(230); lit("s4_d2_off", 4'b1111, 7'h7F, 1'b1);
    run_to(245); lit("s4_d3_on",  4'b0111, 7'b0000000, 1'b1);
    run_to(260); lit("s4_d0_off", 4'b1111, 7'h7F, 1'b1);
    run_to(280); lit("s4_d1_dp",  4'b1101, 7'b0000000, 1'b0);

    // Scenario 5: load on the slot-wrap edge, then value changes without load
    run_to(303);
    en_mask = 4'hF; dp = 4'h0; value = 16'h7654; load = 1'b1;
    step(); load = 1'b0; value = 16'h0000;
    run_to(305); lit("s5_wrap_load", 4'b0111, 7'b1111000, 1'b1);
    run_to(320); value = 16'hFFFF;
    run_to(325); lit("s5_hold", 4'b1110, 7'b0011001, 1'b1);

    // Scenario 6: async reset mid-slot at index 2
    run_to(358); lit("s6_pre", 4'b1011, 7'b0000010, 1'b1);
    #2 rst_n = 1'b0;
    #1 lit("s6_async_dark", 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
    step(); lit("s6_restart", 4'b1110, 7'b1000000, 1'b1);

    // Randomized traffic, checked by the model each cycle
    for (int k = 0; k < 3000; k++) begin
      step();
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en_mask = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 31) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 63) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 lit("rand_async_dark", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
